// File: rtl/link_receiver.sv
// Receive-side elastic buffer: valid/ready in, valid/ready out, DEPTH-word FIFO.
// Optional macro LINK_PARITY_EN adds even-parity checking with a saturating error counter.
module link_receiver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
`ifdef LINK_PARITY_EN
  input  logic                       in_parity,
  output logic [7:0]                 parity_errs,
`endif
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Handshake rule on both sides: a word moves on a rising edge only when
  // valid and ready are both high; ready never depends on valid.

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             parity_ok;
  logic             push, pop;

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign level     = level_q;

`ifdef LINK_PARITY_EN
  logic [7:0] errs_q, errs_d;

  assign parity_ok   = ((^in_data) == in_parity);
  assign parity_errs = errs_q;
  // Gated so that the register-reset value of 0 shows while the buffer is empty.
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    errs_d = errs_q;
    if (in_valid && in_ready && !parity_ok && (errs_q != 8'hFF))
      errs_d = errs_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) errs_q <= '0;
    else     errs_q <= errs_d;
  end
`else
  assign parity_ok = 1'b1;
  assign out_data  = mem_q[rd_ptr_q];
`endif

  assign push = in_valid && in_ready && parity_ok;
  assign pop  = out_valid && out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; stale contents are never visible through out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_link_receiver.sv
// Directed bench for link_receiver: vector table plus reset, drain, wrap and parity sequences.
module tb_link_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] level;
`ifdef LINK_PARITY_EN
  logic       in_parity;
  logic [7:0] parity_errs;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  link_receiver #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
`ifdef LINK_PARITY_EN
    .in_parity(in_parity), .parity_errs(parity_errs),
`endif
    .level(level)
  );

  typedef struct {
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic [2:0] lvl;
    logic       ov;
    logic       ir;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
`ifdef LINK_PARITY_EN
    in_parity = ^d;
`endif
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    #2;
    check("reset_level", level, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
`ifdef LINK_PARITY_EN
    check("reset_out_data", out_data, 0);
    check("reset_parity_errs", parity_errs, 0);
`endif
    #10 rst = 1'b0;
    tick();

    // iv din ordy | level ov ir dout
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 1'b1, 8'h11};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 1'b1, 8'h11};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 1'b1, 8'h11};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 1'b0, 8'h11};
    tbl[4]  = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 1'b0, 8'h11};
    tbl[5]  = '{1'b1, 8'h55, 1'b1, 3'd3, 1'b1, 1'b1, 8'h22};
    tbl[6]  = '{1'b1, 8'h55, 1'b1, 3'd3, 1'b1, 1'b1, 8'h33};
    tbl[7]  = '{1'b0, 8'h66, 1'b1, 3'd2, 1'b1, 1'b1, 8'h44};
    tbl[8]  = '{1'b0, 8'hAA, 1'b0, 3'd2, 1'b1, 1'b1, 8'h44};
    tbl[9]  = '{1'b0, 8'hBB, 1'b1, 3'd1, 1'b1, 1'b1, 8'h55};
    tbl[10] = '{1'b0, 8'hCC, 1'b1, 3'd0, 1'b0, 1'b1, 8'h00};
    tbl[11] = '{1'b0, 8'hDD, 1'b1, 3'd0, 1'b0, 1'b1, 8'h00};

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].iv, tbl[i].din, tbl[i].ordy);
      tick();
      check($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
      check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].ir);
      if (tbl[i].ov) check($sformatf("vec%0d_out_data", i), out_data, tbl[i].dout);
    end

    // Fill then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
      tick();
    end
    check("fill_level", level, 4);
    check("fill_in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      check($sformatf("drain%0d_data", i), out_data, 8'(8'h11 * (i + 1)));
      check($sformatf("drain%0d_valid", i), out_valid, 1);
      tick();
    end
    check("drain_empty", out_valid, 0);

    // Concurrent push/pop at level 2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 1'b0);
      exp_q.push_back(8'(8'hA0 + i));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'hA2 + i), 1'b1);
      check($sformatf("conc%0d_data", i), out_data, exp_q.pop_front());
      exp_q.push_back(8'(8'hA2 + i));
      tick();
      check($sformatf("conc%0d_level", i), level, 2);
    end
    drive(1'b0, 8'h00, 1'b1);
    while (exp_q.size() > 0) begin
      check("conc_tail_data", out_data, exp_q.pop_front());
      tick();
    end
    check("conc_tail_empty", out_valid, 0);

    // Asynchronous reset with three words buffered.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h70 + i), 1'b0);
      tick();
    end
    check("pre_rst_level", level, 3);
    drive(1'b0, 8'h00, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_level", level, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h5A, 1'b0);
    tick();
    check("post_rst_level", level, 1);
    check("post_rst_data", out_data, 8'h5A);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    check("post_rst_empty", out_valid, 0);

`ifdef LINK_PARITY_EN
    drive(1'b1, 8'h03, 1'b0);
    in_parity = 1'b1;
    tick();
    check("par_drop_level", level, 0);
    check("par_errs_1", parity_errs, 1);
    drive(1'b1, 8'h03, 1'b0);
    tick();
    check("par_good_level", level, 1);
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      in_parity = ~(^in_data);
      tick();
    end
    check("par_sat", parity_errs, 255);
    check("par_sat_level", level, 1);
`endif

    drive(1'b0, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
